// File: rtl/mmio_seg7.sv
// MMIO 8-digit multiplexed seven-segment display with active-low anode/cathode pins.
// Optional SEG7_BRIGHTNESS_EN macro adds a BRIGHT register and PWM anode dimming.
module mmio_seg7 #(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        mmio_read,
  input  logic        mmio_write,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_write_data,
  output logic        mmio_work,
  output logic        mmio_done,
  output logic [31:0] mmio_read_data,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   data_r;
  logic [7:0]    enable_r;
  logic [7:0]    dp_r;
  logic [3:0]    word;
  logic [31:0]   rd_mux;
  logic [3:0]    nib;
  logic [7:0]    an_next;
`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0]    bright_r;
  logic [3:0]    pwm;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, mmio_addr[1:0], mmio_write_data[31:8]};

  assign word      = mmio_addr[5:2];
  assign mmio_work = (mmio_addr[31:16] == 16'hFFFF) && (mmio_addr[15:6] == 10'b0000000110);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    rd_mux = '0;
    case (word)
      4'd0: rd_mux = data_r;
      4'd1: rd_mux = {24'b0, enable_r};
      4'd2: rd_mux = {24'b0, dp_r};
`ifdef SEG7_BRIGHTNESS_EN
      4'd3: rd_mux = {28'b0, bright_r};
`endif
      default: rd_mux = '0;
    endcase
  end

  // Bus handshake: a completed cycle always forces one idle cycle before the next.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      data_r         <= RESET_VALUE;
      enable_r       <= 8'hFF;
      dp_r           <= '0;
`ifdef SEG7_BRIGHTNESS_EN
      bright_r       <= 4'hF;
`endif
      mmio_done      <= 1'b0;
      mmio_read_data <= '0;
    end else if (mmio_done) begin
      mmio_done      <= 1'b0;
      mmio_read_data <= '0;
    end else if (mmio_work && mmio_write) begin
      mmio_done      <= 1'b1;
      mmio_read_data <= '0;
      case (word)
        4'd0: data_r   <= mmio_write_data;
        4'd1: enable_r <= mmio_write_data[7:0];
        4'd2: dp_r     <= mmio_write_data[7:0];
`ifdef SEG7_BRIGHTNESS_EN
        4'd3: bright_r <= mmio_write_data[3:0];
`endif
        default: ;
      endcase
    end else if (mmio_work && mmio_read) begin
      mmio_done      <= 1'b1;
      mmio_read_data <= rd_mux;
    end else begin
      mmio_done      <= 1'b0;
      mmio_read_data <= '0;
    end
  end

  always_comb begin
    nib     = data_r[{idx, 2'b00} +: 4];
    an_next = '1;
`ifdef SEG7_BRIGHTNESS_EN
    if ((cnt >= CW'(BLANK_CYC)) && enable_r[idx] && (pwm <= bright_r))
`else
    if ((cnt >= CW'(BLANK_CYC)) && enable_r[idx])
`endif
      an_next = ~(8'b1 << idx);
  end

  // Pins are registered from the current cnt/idx, so they trail the scan counter by one cycle.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      seg_an  <= '1;
      seg_cat <= '1;
`ifdef SEG7_BRIGHTNESS_EN
      pwm     <= '0;
`endif
    end else begin
      if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg_an  <= an_next;
      seg_cat <= {~dp_r[idx], ~hex7(nib)};
`ifdef SEG7_BRIGHTNESS_EN
      pwm     <= pwm + 4'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_seg7.sv
// Directed self-checking bench for mmio_seg7 (SCAN_DIV=32, BLANK_CYC=16).
module tb_mmio_seg7;

  localparam logic [31:0] RV   = 32'h1234_5678;
  localparam logic [31:0] BASE = 32'hFFFF_0180;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_read = 1'b0;
  logic        mmio_write = 1'b0;
  logic [31:0] mmio_addr = BASE;
  logic [31:0] mmio_write_data = '0;
  logic        mmio_work;
  logic        mmio_done;
  logic [31:0] mmio_read_data;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  mmio_seg7 #(.SCAN_DIV(32), .BLANK_CYC(16), .RESET_VALUE(RV)) dut (
    .sys_clk(sys_clk), .rst(rst), .mmio_read(mmio_read), .mmio_write(mmio_write),
    .mmio_addr(mmio_addr), .mmio_write_data(mmio_write_data), .mmio_work(mmio_work),
    .mmio_done(mmio_done), .mmio_read_data(mmio_read_data), .seg_an(seg_an), .seg_cat(seg_cat)
  );

  always #5 sys_clk = ~sys_clk;

  // Edges since reset release; pins after edge n reflect scan position n-1.
  always @(posedge sys_clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] w, input logic [31:0] d);
    mmio_addr = BASE + {26'b0, w, 2'b00};
    mmio_write_data = d;
    mmio_write = 1'b1;
    tick();
    check("wr_done", {31'b0, mmio_done}, 32'd1);
    mmio_write = 1'b0;
    tick();
    check("wr_done_clr", {31'b0, mmio_done}, 32'd0);
  endtask

  task automatic bus_read(input string tag, input logic [3:0] w, input logic [31:0] exp);
    mmio_addr = BASE + {26'b0, w, 2'b00};
    mmio_read = 1'b1;
    tick();
    check("rd_done", {31'b0, mmio_done}, 32'd1);
    check(tag, mmio_read_data, exp);
    mmio_read = 1'b0;
    tick();
    check("rd_data_clr", mmio_read_data, 32'd0);
  endtask

  task automatic wait_pos(input int unsigned slot, input int unsigned off);
    bit found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (((cyc - 1) % 32 == off) && (((cyc - 1) / 32) % 8 == slot)) found = 1;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_pos: slot %0d offset %0d not reached", slot, off);
    end
  endtask

  initial begin
    int unsigned lows;
    repeat (3) tick();
    check("rst_an", {24'b0, seg_an}, 32'hFF);
    check("rst_cat", {24'b0, seg_cat}, 32'hFF);
    check("rst_done", {31'b0, mmio_done}, 32'd0);
    check("rst_rdata", mmio_read_data, 32'd0);
    rst = 1'b0;

    mmio_addr = 32'hFFFF_0180; #1;
    check("work_hit", {31'b0, mmio_work}, 32'd1);
    mmio_addr = 32'hFFFF_0140; #1;
    check("work_miss", {31'b0, mmio_work}, 32'd0);
    mmio_addr = 32'hFFFF_01C0; #1;
    check("work_above", {31'b0, mmio_work}, 32'd0);

    bus_read("rd_data_rst", 4'd0, RV);
    bus_read("rd_en_rst", 4'd1, 32'hFF);
    bus_read("rd_dp_rst", 4'd2, 32'h0);
`ifdef SEG7_BRIGHTNESS_EN
    bus_read("rd_bright_rst", 4'd3, 32'hF);
`else
    bus_read("rd_w3_rst", 4'd3, 32'h0);
`endif

    bus_write(4'd0, 32'h0000_0008);
    wait_pos(0, 15);
    check("s0_blank_an", {24'b0, seg_an}, 32'hFF);
    check("s0_blank_cat", {24'b0, seg_cat}, 32'h80);
    tick();
    check("s0_an", {24'b0, seg_an}, 32'hFE);
    check("s0_cat", {24'b0, seg_cat}, 32'h80);
    wait_pos(0, 31);
    check("s0_last_an", {24'b0, seg_an}, 32'hFE);
    tick();
    check("s1_first_an", {24'b0, seg_an}, 32'hFF);

    bus_write(4'd0, 32'h0000_00F0);
    bus_write(4'd2, 32'h0000_0002);
    wait_pos(1, 5);
    check("s1_blank_an", {24'b0, seg_an}, 32'hFF);
    check("s1_blank_cat", {24'b0, seg_cat}, 32'h0E);
    wait_pos(1, 16);
    check("s1_an", {24'b0, seg_an}, 32'hFD);
    check("s1_cat", {24'b0, seg_cat}, 32'h0E);
    wait_pos(7, 16);
    check("s7_an", {24'b0, seg_an}, 32'h7F);
    check("s7_cat", {24'b0, seg_cat}, 32'hC0);
    wait_pos(0, 20);
    check("s0_wrap_an", {24'b0, seg_an}, 32'hFE);
    check("s0_wrap_cat", {24'b0, seg_cat}, 32'hC0);

    bus_write(4'd1, 32'h0000_0001);
    for (int s = 1; s < 8; s++) begin
      wait_pos(s, 20);
      check("en_off_an", {24'b0, seg_an}, 32'hFF);
    end
    wait_pos(0, 20);
    check("en_on_an", {24'b0, seg_an}, 32'hFE);

    mmio_addr = BASE + 32'h4;
    mmio_write_data = 32'h0000_00A5;
    mmio_write = 1'b1;
    mmio_read = 1'b1;
    tick();
    check("rw_done", {31'b0, mmio_done}, 32'd1);
    check("rw_rdata", mmio_read_data, 32'd0);
    mmio_write = 1'b0;
    mmio_read = 1'b0;
    tick();
    bus_read("rd_en_rw", 4'd1, 32'hA5);

    mmio_addr = BASE + 32'h8;
    mmio_write_data = 32'h0000_0081;
    mmio_write = 1'b1;
    tick();
    check("hold_done1", {31'b0, mmio_done}, 32'd1);
    tick();
    check("hold_gap", {31'b0, mmio_done}, 32'd0);
    tick();
    check("hold_done2", {31'b0, mmio_done}, 32'd1);
    mmio_write = 1'b0;
    tick();
    check("hold_clr", {31'b0, mmio_done}, 32'd0);
    bus_read("rd_dp_hold", 4'd2, 32'h81);

    bus_write(4'd1, 32'hFFFF_FF03);
    bus_read("rd_en_mask", 4'd1, 32'h03);
    bus_write(4'd5, 32'hFFFF_FFFF);
    bus_read("rd_w5", 4'd5, 32'h0);
    bus_read("rd_data_keep", 4'd0, 32'h0000_00F0);

    bus_write(4'd1, 32'h0000_00FF);
    bus_write(4'd3, 32'h0000_0003);
`ifdef SEG7_BRIGHTNESS_EN
    bus_read("rd_bright", 4'd3, 32'h3);
    wait_pos(2, 15);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (seg_an != 8'hFF) lows++;
    end
    check("pwm_duty", lows, 32'd4);
`else
    bus_read("rd_w3", 4'd3, 32'h0);
    wait_pos(2, 15);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (seg_an != 8'hFF) lows++;
    end
    check("full_duty", lows, 32'd16);
`endif

    mmio_addr = BASE + 32'h4;
    mmio_write_data = 32'h0;
    mmio_write = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_mid_done", {31'b0, mmio_done}, 32'd0);
    check("rst_mid_rdata", mmio_read_data, 32'd0);
    mmio_write = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    bus_read("rd_en_after_rst", 4'd1, 32'hFF);
    bus_read("rd_dp_after_rst", 4'd2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
